uart_rx_oversampled: RTL

Parametrised next-generation UART receiver for the UART subsystem. It generates its own oversampling tick and uses 3-sample majority voting per bit. Data width, parity mode and stop-bit count are configurable. It reports parity, framing and overrun errors, and delivers each frame over a valid/ready handshake, so a slow consumer never silently loses data.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tick_gen.sv | 24 ++
 rtl/uart_rx_oversampled.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampled UART blocks.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Receiver states; prefixed so they cannot collide with module parameters.
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK_WAIT
  } rx_state_e;

  // Clock cycles per oversample tick, truncated (100 MHz, 115200, x16 -> 54).
  function automatic int calc_clks_per_tick(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running oversample tick; one-cycle pulse every CLKS_PER_TICK clocks.
// Never re-phased by line activity so RX and TX can share it.
module uart_tick_gen #(
  parameter int CLKS_PER_TICK = 54
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (CLKS_PER_TICK > 2) ? $clog2(CLKS_PER_TICK) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLKS_PER_TICK - 1));

  // Count 0..CLKS_PER_TICK-1 and wrap on the terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: 3-sample majority per bit, optional parity,
// 1/2 stop bits, valid/ready delivery with sticky overrun.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = calc_clks_per_tick(100_000_000, 115200, 16),
  parameter int OVERSAMPLE    = 16,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int H  = OVERSAMPLE / 2;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = 4;

  rx_state_e            state, state_nx;
  logic                 tick;
  logic                 rx_meta, rx_s;
  logic [SW-1:0]        scnt;
  logic [BW-1:0]        bcnt;
  logic                 v0, v1;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_acc, ferr_acc;
  logic                 at_dec, at_end, maj, last_data, last_stop, par_bad;
  logic                 frame_done;

  uart_tick_gen #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

  assign at_dec    = tick && (scnt == SW'(H + 1));
  assign at_end    = tick && (scnt == SW'(OVERSAMPLE - 1));
  assign maj       = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
  assign last_data = (bcnt == BW'(DATA_BITS - 1));
  assign last_stop = (bcnt == BW'(STOP_BITS - 1));
  assign par_bad   = (PARITY == PAR_ODD) ? ~(^shreg ^ maj) : (^shreg ^ maj);
  assign rx_busy   = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next state; the frame completes at the final stop-bit decision, not at
  // the period end, leaving half a bit of slack for back-to-back frames.
  always_comb begin
    state_nx   = state;
    frame_done = 1'b0;
    case (state)
      S_IDLE:       if (tick && !rx_s) state_nx = S_START;
      S_START: begin
        if (at_dec && maj) state_nx = S_IDLE;
        else if (at_end)   state_nx = S_DATA;
      end
      S_DATA:       if (at_end && last_data)
                      state_nx = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
      S_PARITY:     if (at_end) state_nx = S_STOP;
      S_STOP: begin
        if (at_dec && last_stop) begin
          frame_done = 1'b1;
          state_nx   = (!maj && shreg == '0) ? S_BREAK_WAIT : S_IDLE;
        end
      end
      S_BREAK_WAIT: if (tick && rx_s) state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  // Bit timing, majority votes, shift register and per-frame error accumulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scnt     <= '0;
      bcnt     <= '0;
      v0       <= 1'b1;
      v1       <= 1'b1;
      shreg    <= '0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
    end else if (state == S_IDLE) begin
      scnt     <= '0;
      bcnt     <= '0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      if (tick) scnt <= (scnt == SW'(OVERSAMPLE - 1)) ? '0 : scnt + SW'(1);
      if (tick && scnt == SW'(H - 1)) v0 <= rx_s;
      if (tick && scnt == SW'(H))     v1 <= rx_s;
      if (state == S_DATA && at_dec)   shreg <= {maj, shreg[DATA_BITS-1:1]};
      if (state == S_PARITY && at_dec) perr_acc <= par_bad;
      if (state == S_STOP && at_dec && !maj) ferr_acc <= 1'b1;
      if (at_end && state == S_DATA)  bcnt <= last_data ? '0 : bcnt + BW'(1);
      if (at_end && state == S_STOP)  bcnt <= bcnt + BW'(1);
    end
  end

  // Output holding register: load on commit if free or being accepted,
  // otherwise drop the new frame and flag overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (frame_done) begin
      if (!rx_valid || rx_ready) begin
        rx_data     <= shreg;
        rx_valid    <= 1'b1;
        parity_err  <= perr_acc;
        frame_err   <= ferr_acc | ~maj;
        overrun_err <= 1'b0;
      end else begin
        overrun_err <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid    <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

endmodule
